// File: rtl/mul_signed_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_signed_seq_if
//  Description : Handshake and result bundle for the sequential signed
//                multiplier. The master launches an operation with start/a/b.
//                The slave (the multiplier) returns busy/done and the results.
//  Ports       : start   - launch request, sampled only when the unit is idle
//                a, b    - signed operands, WIDTH bits
//                busy    - operation in progress
//                done    - one-cycle pulse when the results update
//                m       - WIDTH-bit result, wrapped or saturated
//                p_full  - exact 2*WIDTH-bit signed product
//                of_mul  - product does not fit in WIDTH signed bits
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_signed_seq_if #(
   parameter int WIDTH = 6
) ();
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [WIDTH-1:0]     m;
   logic [2*WIDTH-1:0]   p_full;
   logic                 of_mul;

   modport master (
      output start, a, b,
      input  busy, done, m, p_full, of_mul
   );

   modport slave (
      input  start, a, b,
      output busy, done, m, p_full, of_mul
   );
endinterface
`default_nettype wire

// File: rtl/mul_signed_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_signed_seq
//  Description : Multi-cycle shift-add signed multiplier. The operands are
//                reduced to unsigned magnitudes on capture. The magnitudes are
//                multiplied over WIDTH iterations, and the sign is applied in
//                a final cycle. That cycle also computes the exact overflow
//                flag and the wrapped or saturated short result.
//  Ports       : clk     - clock, rising edge
//                rst     - synchronous active-high reset
//                bus     - slave side of mul_signed_seq_if
//                          (start/a/b in; busy/done/m/p_full/of_mul out)
//  Parameters  : WIDTH   - operand and short-result width (>= 2)
//                SAT_EN  - 0: wrap on overflow, 1: saturate to signed max/min
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_signed_seq #(
   parameter int WIDTH  = 6,
   parameter bit SAT_EN = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   mul_signed_seq_if.slave bus
);
   localparam int                CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]     C_LAST    = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0]  C_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]  C_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic [2*WIDTH-1:0]   r_mcand;    // shifted multiplicand magnitude
   logic [2*WIDTH-1:0]   r_acc;      // unsigned magnitude accumulator
   logic [WIDTH-1:0]     r_mplier;   // multiplier magnitude, consumed LSB first
   logic [CW-1:0]        r_cnt;
   logic                 r_sign;

   logic [2*WIDTH-1:0]   r_p_full;
   logic [WIDTH-1:0]     r_m;
   logic                 r_of;
   logic                 r_done;

   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH:0]       w_top;
   logic                 w_of;
   logic [WIDTH-1:0]     w_m;

   // Negating the most-negative value yields 2^(WIDTH-1). That value is
   // correct when the field is read as an unsigned magnitude.
   assign w_mag_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign w_mag_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

   // A zero magnitude stays zero under negation, so there is no negative zero.
   assign w_prod  = r_sign ? -r_acc : r_acc;

   // The product fits in WIDTH signed bits only when the upper WIDTH+1 bits
   // are all copies of the sign.
   assign w_top   = w_prod[2*WIDTH-1:WIDTH-1];
   assign w_of    = ~((&w_top) | ~(|w_top));

   assign w_m     = (SAT_EN && w_of) ? (w_prod[2*WIDTH-1] ? C_SAT_NEG : C_SAT_POS)
                                     : w_prod[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_CALC;
         S_CALC:  if (r_cnt == C_LAST) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_sign   <= 1'b0;
         r_p_full <= '0;
         r_m      <= '0;
         r_of     <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mplier <= w_mag_b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_sign   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
               end
            end
            S_CALC: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + r_mcand;
               end
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
            end
            S_FIN: begin
               r_p_full <= w_prod;
               r_of     <= w_of;
               r_m      <= w_m;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (r_state != S_IDLE);
   assign bus.done   = r_done;
   assign bus.m      = r_m;
   assign bus.p_full = r_p_full;
   assign bus.of_mul = r_of;

endmodule
`default_nettype wire
